// File: rtl/serial_paralelo_sync.sv
// serial_paralelo_sync
//   Serial-to-parallel receiver with comma-based word alignment.
//   The receiver hunts for COMMA at any bit offset. It locks after LOCK_COUNT
//   consecutive aligned commas. After lock it emits non-comma words on
//   data2send, each with a one-cycle valid_out strobe.
//
//   Optional build macro: SP_SLIP_DETECT_EN
//     When defined, SLIP_LIMIT consecutive misaligned commas while locked
//     drop the link back to hunting.
//
// Ports
//   clk_8f      in   serial bit clock, all logic on the rising edge
//   reset       in   synchronous, active-high reset
//   data_in     in   serial data, MSB of each word first
//   data2send   out  [WIDTH-1:0] received parallel word
//   valid_out   out  one-cycle strobe, data2send holds a new non-comma word
//   active      out  link locked
//   BC_counter  out  [CNT_W-1:0] aligned commas since last hunt, saturating
//
// States
//   HUNT   | compare every cycle, looking for a comma at any bit offset
//   ALIGN  | word boundary found, counting consecutive aligned commas
//   ACTIVE | locked, forwarding data words and counting idle commas
module serial_paralelo_sync #(
  parameter int               WIDTH      = 8,
  parameter logic [WIDTH-1:0] COMMA      = 8'hBC,
  parameter int               LOCK_COUNT = 4,
  parameter int               CNT_W      = 4,
  parameter int               SLIP_LIMIT = 3
) (
  input  logic             clk_8f,
  input  logic             reset,
  input  logic             data_in,
  output logic [WIDTH-1:0] data2send,
  output logic             valid_out,
  output logic             active,
  output logic [CNT_W-1:0] BC_counter
);

  localparam int               BIT_W    = $clog2(WIDTH);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] BC_MAX   = '1;
  localparam logic [CNT_W-1:0] LOCK_VAL = CNT_W'(LOCK_COUNT);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    ALIGN  = 2'd1,
    ACTIVE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sr;
  logic [BIT_W-1:0] bit_cnt, bit_cnt_nxt, bit_cnt_inc;
  logic [CNT_W-1:0] bc_nxt, bc_inc;
  logic [WIDTH-1:0] data_nxt;
  logic             valid_nxt, active_nxt;
  logic             is_comma, word_tick;

`ifdef SP_SLIP_DETECT_EN
  localparam int               SLIP_W   = $clog2(SLIP_LIMIT + 1);
  localparam logic [SLIP_W-1:0] SLIP_VAL = SLIP_W'(SLIP_LIMIT);
  logic [SLIP_W-1:0] slip_cnt, slip_nxt, slip_inc;
  assign slip_inc = slip_cnt + 1'b1;
`endif

  assign is_comma    = (sr == COMMA);
  // Only meaningful in ALIGN/ACTIVE; in HUNT the bit counter is free-running.
  assign word_tick   = (bit_cnt == '0);
  assign bit_cnt_inc = (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;
  assign bc_inc      = BC_counter + 1'b1;

  always_ff @(posedge clk_8f) begin
    if (reset) begin
      state      <= HUNT;
      sr         <= '0;
      bit_cnt    <= '0;
      BC_counter <= '0;
      data2send  <= '0;
      valid_out  <= 1'b0;
      active     <= 1'b0;
`ifdef SP_SLIP_DETECT_EN
      slip_cnt   <= '0;
`endif
    end else begin
      state      <= state_nxt;
      sr         <= {sr[WIDTH-2:0], data_in};
      bit_cnt    <= bit_cnt_nxt;
      BC_counter <= bc_nxt;
      data2send  <= data_nxt;
      valid_out  <= valid_nxt;
      active     <= active_nxt;
`ifdef SP_SLIP_DETECT_EN
      slip_cnt   <= slip_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt_inc;
    bc_nxt      = BC_counter;
    data_nxt    = data2send;
    valid_nxt   = 1'b0;
    active_nxt  = active;
`ifdef SP_SLIP_DETECT_EN
    slip_nxt    = '0;
`endif

    unique case (state)
      HUNT: begin
        if (is_comma) begin
          // The comma just matched ends a word. The edge that takes us out of
          // HUNT also shifts in bit 1 of the next word, so the counter restarts at 1.
          bit_cnt_nxt = BIT_W'(1);
          bc_nxt      = CNT_W'(1);
          if (LOCK_COUNT == 1) begin
            state_nxt  = ACTIVE;
            active_nxt = 1'b1;
          end else begin
            state_nxt  = ALIGN;
          end
        end
      end

      ALIGN: begin
        if (word_tick) begin
          if (is_comma) begin
            bc_nxt = bc_inc;
            if (bc_inc == LOCK_VAL) begin
              state_nxt  = ACTIVE;
              active_nxt = 1'b1;
            end
          end else begin
            state_nxt = HUNT;
            bc_nxt    = '0;
          end
        end
      end

      ACTIVE: begin
`ifdef SP_SLIP_DETECT_EN
        slip_nxt = slip_cnt;
`endif
        if (word_tick) begin
          if (!is_comma) begin
            data_nxt  = sr;
            valid_nxt = 1'b1;
          end else begin
            if (BC_counter != BC_MAX) bc_nxt = bc_inc;
`ifdef SP_SLIP_DETECT_EN
            slip_nxt = '0;
`endif
          end
        end
`ifdef SP_SLIP_DETECT_EN
        else if (is_comma) begin
          if (slip_inc == SLIP_VAL) begin
            state_nxt  = HUNT;
            active_nxt = 1'b0;
            bc_nxt     = '0;
            valid_nxt  = 1'b0;
            slip_nxt   = '0;
          end else begin
            slip_nxt   = slip_inc;
          end
        end
`endif
      end

      default: begin
        state_nxt = HUNT;
      end
    endcase
  end

endmodule

// File: tb/tb_serial_paralelo_sync.sv
// tb_serial_paralelo_sync
//   Bench for serial_paralelo_sync with default parameters. Expected outputs
//   come from a model that works on the whole bit stream. The model searches
//   the stream for comma windows and then steps through it in 8-bit words
//   from the found boundary.
module tb_serial_paralelo_sync;

  localparam int         WIDTH      = 8;
  localparam int         CNT_W      = 4;
  localparam int         LOCK_COUNT = 4;
  localparam int         BC_SAT     = 15;
  localparam logic [7:0] COMMA      = 8'hBC;
  localparam int         MAXN       = 512;

  logic       clk_8f = 1'b0;
  logic       reset  = 1'b1;
  logic       data_in = 1'b0;
  logic [7:0] data2send;
  logic       valid_out;
  logic       active;
  logic [3:0] BC_counter;

  int n_cmp = 0;
  int n_err = 0;

  // Packed snapshot layout: [13]=valid_out [12]=active [11:8]=BC_counter [7:0]=data2send
  logic        stream [$];
  logic [13:0] expv [MAXN];
  logic [13:0] obs  [MAXN];
  int          ev_bc    [MAXN];
  logic        ev_act   [MAXN];
  logic        ev_valid [MAXN];
  logic [7:0]  ev_data  [MAXN];
  int          pulse_e [$];
  logic [7:0]  pulse_d [$];

  serial_paralelo_sync #(
    .WIDTH(WIDTH), .COMMA(COMMA), .LOCK_COUNT(LOCK_COUNT), .CNT_W(CNT_W), .SLIP_LIMIT(3)
  ) dut (
    .clk_8f(clk_8f), .reset(reset), .data_in(data_in),
    .data2send(data2send), .valid_out(valid_out), .active(active), .BC_counter(BC_counter)
  );

  always #5 clk_8f = ~clk_8f;

  function automatic void add_word(input logic [7:0] w);
    for (int k = 7; k >= 0; k--) stream.push_back(w[k]);
  endfunction

  function automatic void add_rand_bits(input int k);
    for (int i = 0; i < k; i++) stream.push_back(1'($urandom_range(0, 1)));
  endfunction

  // 8-bit window of the stream ending at bit w. Bits before the stream start are 0 after reset.
  function automatic logic [7:0] win(input int w);
    logic [7:0] r;
    r = '0;
    for (int k = w - 7; k <= w; k++) r = {r[6:0], (k >= 0) ? stream[k] : 1'b0};
    return r;
  endfunction

  // A window ending at bit i is seen by the hunter at edge i+1. Aligned words then
  // end every 8 bits after the match, and each takes effect at the following edge.
  function automatic void build_model();
    int  n, pos, p, w, cnt, cb;
    bit  locked, failed, done;
    logic       ca;
    logic [7:0] cd;
    n = stream.size();
    for (int e = 0; e < MAXN; e++) begin
      ev_bc[e] = -1; ev_act[e] = 0; ev_valid[e] = 0; ev_data[e] = '0;
    end
    pos = 0; done = 0;
    while (!done) begin
      p = -1;
      for (int i = pos; i + 1 < n && p < 0; i++) if (win(i) == COMMA) p = i;
      if (p < 0) begin
        done = 1;
      end else begin
        cnt = 1; ev_bc[p+1] = 1;
        locked = (LOCK_COUNT == 1);
        if (locked) ev_act[p+1] = 1;
        w = p + 8; failed = 0;
        while (!locked && !failed && w + 1 < n) begin
          if (win(w) == COMMA) begin
            cnt++; ev_bc[w+1] = cnt;
            if (cnt == LOCK_COUNT) begin locked = 1; ev_act[w+1] = 1; end
            w += 8;
          end else begin
            failed = 1; ev_bc[w+1] = 0;
          end
        end
        if (failed) begin
          pos = w + 1;
        end else begin
          if (locked) begin
            for (; w + 1 < n; w += 8) begin
              if (win(w) == COMMA) begin
                cnt = (cnt < BC_SAT) ? cnt + 1 : BC_SAT; ev_bc[w+1] = cnt;
              end else begin
                ev_valid[w+1] = 1; ev_data[w+1] = win(w);
              end
            end
          end
          done = 1;
        end
      end
    end
    cb = 0; ca = 0; cd = '0;
    for (int e = 0; e < n; e++) begin
      if (ev_bc[e] >= 0) cb = ev_bc[e];
      if (ev_act[e]) ca = 1'b1;
      if (ev_valid[e]) cd = ev_data[e];
      expv[e] = {ev_valid[e], ca, 4'(cb), cd};
    end
  endfunction

  // Entered at a negedge with reset asserted; bit 0 is captured by the first edge after release.
  task automatic run_stream();
    int n;
    n = stream.size();
    build_model();
    reset = 1'b0;
    data_in = stream[0];
    for (int e = 0; e < n; e++) begin
      @(negedge clk_8f);
      obs[e] = {valid_out, active, BC_counter, data2send};
      if (e + 1 < n) data_in = stream[e+1];
    end
  endtask

  task automatic apply_reset(input int k);
    reset = 1'b1;
    repeat (k) @(negedge clk_8f);
  endtask

  function automatic void collect_pulses();
    pulse_e.delete(); pulse_d.delete();
    for (int e = 0; e < stream.size(); e++)
      if (obs[e][13]) begin pulse_e.push_back(e); pulse_d.push_back(obs[e][7:0]); end
  endfunction

  task automatic test_reset();
    reset = 1'b1; data_in = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_8f);
      n_cmp++;
      if ({valid_out, active, BC_counter, data2send} !== 14'h0) begin
        n_err++;
        $display("FAIL reset cycle %0d got %h want 0000", i, {valid_out, active, BC_counter, data2send});
      end
    end
  endtask

  task automatic test_basic();
    stream.delete();
    for (int i = 0; i < 4; i++) add_word(COMMA);
    add_word(8'hA5); add_word(8'h3C); add_word(COMMA);
    run_stream();
    for (int e = 0; e < stream.size(); e++) begin
      n_cmp++;
      if (obs[e] !== expv[e]) begin
        n_err++; $display("FAIL basic edge %0d got %h want %h", e, obs[e], expv[e]);
      end
    end
    for (int k = 1; k <= 4; k++) begin
      n_cmp++;
      if (obs[8*k][11:8] !== 4'(k)) begin
        n_err++; $display("FAIL basic_bc%0d got %0d want %0d", k, obs[8*k][11:8], k);
      end
    end
    n_cmp++;
    if (obs[31][12] !== 1'b0 || obs[32][12] !== 1'b1) begin
      n_err++; $display("FAIL basic_lock_edge got %b%b want 01", obs[31][12], obs[32][12]);
    end
    collect_pulses();
    n_cmp++;
    if (pulse_e.size() != 2 || pulse_e[0] != 40 || pulse_e[1] != 48 ||
        pulse_d[0] !== 8'hA5 || pulse_d[1] !== 8'h3C) begin
      n_err++; $display("FAIL basic_pulses got count %0d want 2 at edges 40/48 with A5/3C", pulse_e.size());
    end
  endtask

  task automatic test_offset();
    stream.delete();
    add_rand_bits(3);
    for (int i = 0; i < 4; i++) add_word(COMMA);
    add_word(8'h5A); add_word(COMMA);
    apply_reset(2);
    run_stream();
    for (int e = 0; e < stream.size(); e++) begin
      n_cmp++;
      if (obs[e] !== expv[e]) begin
        n_err++; $display("FAIL offset edge %0d got %h want %h", e, obs[e], expv[e]);
      end
    end
    collect_pulses();
    n_cmp++;
    if (pulse_e.size() != 1 || pulse_e[0] != 43 || pulse_d[0] !== 8'h5A) begin
      n_err++; $display("FAIL offset_pulse got count %0d want 1 at edge 43 with 5A", pulse_e.size());
    end
  endtask

  task automatic test_align_fail();
    stream.delete();
    add_word(COMMA); add_word(COMMA); add_word(8'h12);
    for (int i = 0; i < 4; i++) add_word(COMMA);
    add_word(8'h77); add_word(COMMA);
    apply_reset(2);
    run_stream();
    for (int e = 0; e < stream.size(); e++) begin
      n_cmp++;
      if (obs[e] !== expv[e]) begin
        n_err++; $display("FAIL align_fail edge %0d got %h want %h", e, obs[e], expv[e]);
      end
    end
    n_cmp++;
    if (obs[24][12:8] !== 5'h00 || obs[23][11:8] !== 4'd2) begin
      n_err++; $display("FAIL align_fail_drop got %h/%h want bc2 then 00", obs[23][12:8], obs[24][12:8]);
    end
    collect_pulses();
    n_cmp++;
    if (pulse_e.size() != 1 || pulse_e[0] != 64 || pulse_d[0] !== 8'h77) begin
      n_err++; $display("FAIL align_fail_relock got count %0d want 1 at edge 64 with 77", pulse_e.size());
    end
  endtask

  task automatic test_saturate();
    int n;
    stream.delete();
    for (int i = 0; i < 4; i++) add_word(COMMA);
    add_word(8'hC3);
    for (int i = 0; i < 20; i++) add_word(COMMA);
    apply_reset(2);
    run_stream();
    n = stream.size();
    for (int e = 0; e < n; e++) begin
      n_cmp++;
      if (obs[e] !== expv[e]) begin
        n_err++; $display("FAIL saturate edge %0d got %h want %h", e, obs[e], expv[e]);
      end
    end
    collect_pulses();
    n_cmp++;
    if (pulse_e.size() != 1 || obs[n-1][11:8] !== 4'd15 || obs[n-1][7:0] !== 8'hC3) begin
      n_err++; $display("FAIL saturate_end got pulses %0d bc %0d data %h want 1 15 c3",
                        pulse_e.size(), obs[n-1][11:8], obs[n-1][7:0]);
    end
  endtask

  task automatic test_midword_reset();
    stream.delete();
    for (int i = 0; i < 4; i++) add_word(COMMA);
    add_word(8'h99); add_rand_bits(3);
    apply_reset(2);
    run_stream();
    for (int e = 0; e < stream.size(); e++) begin
      n_cmp++;
      if (obs[e] !== expv[e]) begin
        n_err++; $display("FAIL mid_pre edge %0d got %h want %h", e, obs[e], expv[e]);
      end
    end
    apply_reset(1);
    n_cmp++;
    if ({valid_out, active, BC_counter, data2send} !== 14'h0) begin
      n_err++; $display("FAIL mid_reset got %h want 0000", {valid_out, active, BC_counter, data2send});
    end
    stream.delete();
    for (int i = 0; i < 4; i++) add_word(COMMA);
    add_word(8'h42); add_word(COMMA);
    run_stream();
    for (int e = 0; e < stream.size(); e++) begin
      n_cmp++;
      if (obs[e] !== expv[e]) begin
        n_err++; $display("FAIL mid_post edge %0d got %h want %h", e, obs[e], expv[e]);
      end
    end
    collect_pulses();
    n_cmp++;
    if (pulse_e.size() != 1 || pulse_d[0] !== 8'h42) begin
      n_err++; $display("FAIL mid_relock got count %0d want 1 pulse with 42", pulse_e.size());
    end
  endtask

  task automatic test_slip();
    int n;
    stream.delete();
    for (int i = 0; i < 4; i++) add_word(COMMA);
    add_word(8'h81); stream.push_back(1'b0);
    for (int i = 0; i < 9; i++) add_word(COMMA);
    add_word(8'h3C); add_word(8'h00);
    apply_reset(2);
    run_stream();
    n = stream.size();
`ifdef SP_SLIP_DETECT_EN
    n_cmp++;
    if (obs[64][12] !== 1'b1 || obs[65][12] !== 1'b0) begin
      n_err++; $display("FAIL slip_drop got %b%b want 10", obs[64][12], obs[65][12]);
    end
    n_cmp++;
    if (obs[n-1][12] !== 1'b1 || obs[n-1][7:0] !== 8'h3C) begin
      n_err++; $display("FAIL slip_relock got active %b data %h want 1 3c", obs[n-1][12], obs[n-1][7:0]);
    end
`else
    for (int e = 0; e < n; e++) begin
      n_cmp++;
      if (obs[e] !== expv[e]) begin
        n_err++; $display("FAIL slip edge %0d got %h want %h", e, obs[e], expv[e]);
      end
    end
    for (int e = 32; e < n; e++) begin
      n_cmp++;
      if (obs[e][12] !== 1'b1) begin
        n_err++; $display("FAIL slip_active edge %0d got %b want 1", e, obs[e][12]);
      end
    end
`endif
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      stream.delete();
      add_rand_bits($urandom_range(0, 7));
      for (int i = 0; i < 4; i++) add_word(COMMA);
      for (int i = 0; i < 5; i++) begin
        if ($urandom_range(0, 3) == 0) add_word(COMMA);
        else add_word(8'($urandom));
      end
      add_rand_bits(9);
      apply_reset(2);
      run_stream();
      for (int e = 0; e < stream.size(); e++) begin
        n_cmp++;
        if (obs[e] !== expv[e]) begin
          n_err++; $display("FAIL random%0d edge %0d got %h want %h", it, e, obs[e], expv[e]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_offset();
    test_align_fail();
    test_saturate();
    test_midword_reset();
    test_slip();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/serial_paralelo_sync.md
Name: serial_paralelo_sync

Overview:
Parametrised serial-to-parallel receiver for the PHY RX path. It takes one serial bit per clk_8f cycle and finds word alignment at any bit offset by hunting for a comma character (default 0xBC). It declares lock after LOCK_COUNT consecutive aligned commas, then emits parallel data words with a one-cycle valid strobe. It succeeds the fixed 8-bit converter: width, comma value and lock threshold are generic, and it can re-align on bit slips.

Parameters:
WIDTH, 8, parallel word width in bits (>=4)
COMMA, 8'hBC, alignment/idle character, WIDTH bits wide
LOCK_COUNT, 4, consecutive aligned commas required to assert active (1..2**CNT_W-1)
CNT_W, 4, width of BC_counter
SLIP_LIMIT, 3, consecutive misaligned commas that force re-hunt (optional feature only)

Ports:
clk_8f  input  1  serial bit clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
data_in  input  1  serial data, MSB of each word first
data2send  output  WIDTH  received parallel word
valid_out  output  1  one-cycle strobe: data2send holds a new non-comma word
active  output  1  link locked, data transfer enabled
BC_counter  output  CNT_W  aligned commas seen since last HUNT, saturating

Behaviour:
- Reset (reset=1 at a clk_8f edge): data2send=0, valid_out=0, active=0, BC_counter=0, shift register=0, bit_cnt=0, state=HUNT. Reset overrides everything, including mid-word and mid-ACTIVE.
- Shift register sr: WIDTH bits. Every edge: sr <= {sr[WIDTH-2:0], data_in}.
- bit_cnt: 0..WIDTH-1, increments each edge, wraps WIDTH-1 -> 0. word_tick = (bit_cnt==0) in ALIGN/ACTIVE. At word_tick, sr holds a complete aligned word.
- HUNT: bit_cnt is ignored. Every cycle, compare sr to COMMA.
  - On match: bit_cnt<=1, BC_counter<=1, go to ALIGN. If LOCK_COUNT==1, go straight to ACTIVE and set active<=1.
- ALIGN, at each word_tick:
  - sr==COMMA: BC_counter+1. If the new count equals LOCK_COUNT, go to ACTIVE and set active<=1 on the same edge.
  - sr!=COMMA: go to HUNT, BC_counter<=0.
  - valid_out stays 0 throughout ALIGN.
- ACTIVE, at each word_tick:
  - sr!=COMMA: data2send<=sr, valid_out<=1 for exactly one cycle.
  - sr==COMMA: idle word. valid_out<=0, data2send holds, BC_counter increments and saturates at 2**CNT_W-1.
  - valid_out is 0 on every non-tick cycle.
- Latency: last bit of word sampled into sr at edge t, word_tick at t, data2send/valid_out visible after edge t+1.
- active stays 1 until reset (or a slip event, see Optional Feature).
- A comma appearing across a word boundary in ALIGN/ACTIVE is ignored. Data content is never checked.

Optional Feature:
Macro SP_SLIP_DETECT_EN.
- Defined: in ACTIVE, a slip_cnt counts cycles with sr==COMMA while bit_cnt!=0, and clears on any aligned comma at word_tick. When slip_cnt reaches SLIP_LIMIT, on that same edge: state<=HUNT, active<=0, BC_counter<=0, valid_out<=0, slip_cnt<=0. Re-hunt then starts on the next cycle.
- Not defined: no slip_cnt logic. Misaligned commas have no effect and ACTIVE persists until reset.

Test Plan:
1. Defaults; reset 5 cycles; send BC x4 then 0xA5, 0x3C -> BC_counter 1..4; active=1 after 4th BC tick; valid_out pulses with data2send=0xA5, then 0x3C, 8 cycles apart.
2. 3 random bits, then BC x4, then 0x5A -> lock at 3-bit offset; data2send=0x5A valid exactly once.
3. BC x2, then 0x12 -> back to HUNT; BC_counter=0, active=0, no valid_out. Then BC x4 -> locks.
4. Locked; send BC x20 -> no valid_out; BC_counter saturates at 15; data2send keeps last data.
5. Locked mid-word; assert reset 1 cycle -> next cycle all outputs 0, state HUNT. BC x4 re-locks.
6. With SP_SLIP_DETECT_EN: locked, then insert 1 extra bit and send BC x3 -> active drops to 0 at 3rd misaligned comma, re-locks at the new offset after the following aligned commas. Without the macro: active stays 1.
